// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM button/config/core path.
package pwm_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Request bit positions; a lower index wins arbitration.
    localparam int REQ_DEC_DUTY = 0;
    localparam int REQ_INC_DUTY = 1;
    localparam int REQ_DEC_FREQ = 2;
    localparam int REQ_INC_FREQ = 3;
    localparam int REQ_NUM      = 4;

    localparam int W_DEF         = 8;
    localparam int DUTY_STEP_DEF = 16;
    localparam int PER_STEP_DEF  = 16;
    localparam int PER_MIN_DEF   = 16;
    localparam int PER_INIT_DEF  = 255;
    localparam int DUTY_INIT_DEF = 0;
    localparam int RAMP_MAX_DEF  = 8;

    function automatic logic [REQ_NUM-1:0] prio_grant(input logic [REQ_NUM-1:0] req);
        return req & (~req + {{(REQ_NUM-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/pwm_cfg_sequencer_if.sv
// Request/commit bundle between the button front-end, the config sequencer and the PWM core.
interface pwm_cfg_sequencer_if
    import pwm_pkg::*;
#(
    parameter int W = W_DEF
) ();

    logic         inc_duty_req;
    logic         dec_duty_req;
    logic         inc_freq_req;
    logic         dec_freq_req;
    logic         period_end;
    logic [W-1:0] duty_out;
    logic [W-1:0] period_out;
    logic         busy;
    logic         req_drop;

    modport master (
        output inc_duty_req, dec_duty_req, inc_freq_req, dec_freq_req, period_end,
        input  duty_out, period_out, busy, req_drop
    );

    modport slave (
        input  inc_duty_req, dec_duty_req, inc_freq_req, dec_freq_req, period_end,
        output duty_out, period_out, busy, req_drop
    );

endinterface

// File: rtl/pwm_sat_step.sv
// Saturating step: up ? min(val+step, hi) : max(val-step, lo). Combinational, 0 cycles.
// No backpressure; W+1-bit intermediates so neither direction wraps.
module pwm_sat_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] val_dat,
    input  logic [W-1:0] step_dat,
    input  logic         up,
    input  logic [W-1:0] lo_dat,
    input  logic [W-1:0] hi_dat,
    output logic [W-1:0] res_dat
);

    logic [W:0] sum_w;
    logic [W:0] diff_w;

    always_comb begin
        sum_w   = {1'b0, val_dat} + {1'b0, step_dat};
        diff_w  = {1'b0, val_dat} - {1'b0, step_dat};
        res_dat = val_dat;
        if (up) begin
            res_dat = (sum_w > {1'b0, hi_dat}) ? hi_dat : sum_w[W-1:0];
        end else begin
            // diff_w[W] set means the subtraction borrowed below zero.
            res_dat = (diff_w[W] || (diff_w[W-1:0] < lo_dat)) ? lo_dat : diff_w[W-1:0];
        end
    end

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Arbitrates duty/freq requests into saturated targets; commits them to the core at period_end.
// Targets update 1 cycle after a request, outputs 1 cycle after period_end; no backpressure, losers pulse req_drop.
module pwm_cfg_sequencer
    import pwm_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int DUTY_STEP = DUTY_STEP_DEF,
    parameter int PER_STEP  = PER_STEP_DEF,
    parameter int PER_MIN   = PER_MIN_DEF,
    parameter int PER_INIT  = PER_INIT_DEF,
    parameter int DUTY_INIT = DUTY_INIT_DEF,
    parameter int RAMP_MAX  = RAMP_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pwm_cfg_sequencer_if.slave bus
);

    localparam logic [W-1:0] DUTY_STEP_W = W'(DUTY_STEP);
    localparam logic [W-1:0] PER_STEP_W  = W'(PER_STEP);
    localparam logic [W-1:0] PER_MIN_W   = W'(PER_MIN);
    localparam logic [W-1:0] PER_MAX_W   = {W{1'b1}};
    localparam logic [W-1:0] PER_INIT_W  = W'(PER_INIT);
    localparam logic [W-1:0] DUTY_INIT_W = W'(DUTY_INIT);
    localparam logic [W-1:0] RAMP_MAX_W  = W'(RAMP_MAX);

    state_e       state_q,    state_d;
    logic [W-1:0] duty_tgt_q, duty_tgt_d;
    logic [W-1:0] per_tgt_q,  per_tgt_d;
    logic [W-1:0] duty_out_q, duty_out_d;
    logic [W-1:0] per_out_q,  per_out_d;
    logic         req_drop_q, req_drop_d;

    logic [REQ_NUM-1:0] req_vec;
    logic [REQ_NUM-1:0] grant_vec;
    logic               duty_grant;
    logic               per_grant;
    logic [W-1:0]       duty_step_res;
    logic [W-1:0]       per_step_res;
    logic [W-1:0]       ramp_res;
    logic [W-1:0]       lim;

    always_comb begin
        req_vec               = '0;
        req_vec[REQ_DEC_DUTY] = bus.dec_duty_req;
        req_vec[REQ_INC_DUTY] = bus.inc_duty_req;
        req_vec[REQ_DEC_FREQ] = bus.dec_freq_req;
        req_vec[REQ_INC_FREQ] = bus.inc_freq_req;
        grant_vec             = prio_grant(req_vec);
        duty_grant            = grant_vec[REQ_DEC_DUTY] | grant_vec[REQ_INC_DUTY];
        per_grant             = grant_vec[REQ_DEC_FREQ] | grant_vec[REQ_INC_FREQ];
        req_drop_d            = |(req_vec & ~grant_vec);
        lim                   = (duty_tgt_q < per_tgt_q) ? duty_tgt_q : per_tgt_q;
    end

    pwm_sat_step #(.W(W)) u_duty_step (
        .val_dat  (duty_tgt_q),
        .step_dat (DUTY_STEP_W),
        .up       (grant_vec[REQ_INC_DUTY]),
        .lo_dat   ('0),
        .hi_dat   (per_tgt_q),
        .res_dat  (duty_step_res)
    );

    pwm_sat_step #(.W(W)) u_per_step (
        .val_dat  (per_tgt_q),
        .step_dat (PER_STEP_W),
        .up       (grant_vec[REQ_DEC_FREQ]),
        .lo_dat   (PER_MIN_W),
        .hi_dat   (PER_MAX_W),
        .res_dat  (per_step_res)
    );

    // Bounds pinned to lim so the ramp settles exactly on the target.
    pwm_sat_step #(.W(W)) u_ramp_step (
        .val_dat  (duty_out_q),
        .step_dat (RAMP_MAX_W),
        .up       (lim > duty_out_q),
        .lo_dat   (lim),
        .hi_dat   (lim),
        .res_dat  (ramp_res)
    );

    always_comb begin
        duty_tgt_d = duty_tgt_q;
        per_tgt_d  = per_tgt_q;
        duty_out_d = duty_out_q;
        per_out_d  = per_out_q;
        state_d    = state_q;

        if (duty_grant) begin
            duty_tgt_d = duty_step_res;
        end else if (per_grant) begin
            per_tgt_d  = per_step_res;
            duty_tgt_d = (duty_tgt_q > per_step_res) ? per_step_res : duty_tgt_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                if ((duty_tgt_d != duty_out_q) || (per_tgt_d != per_out_q)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.period_end) begin
                    per_out_d = per_tgt_q;
                    // A shrinking period clamps duty at once so duty never exceeds period.
                    duty_out_d = (duty_out_q > per_tgt_q) ? per_tgt_q : ramp_res;
                    state_d    = ((duty_out_d != duty_tgt_d) || (per_out_d != per_tgt_d))
                               ? ST_WAIT : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            duty_tgt_q <= DUTY_INIT_W;
            per_tgt_q  <= PER_INIT_W;
            duty_out_q <= DUTY_INIT_W;
            per_out_q  <= PER_INIT_W;
            req_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_tgt_q <= duty_tgt_d;
            per_tgt_q  <= per_tgt_d;
            duty_out_q <= duty_out_d;
            per_out_q  <= per_out_d;
            req_drop_q <= req_drop_d;
        end
    end

    assign bus.duty_out   = duty_out_q;
    assign bus.period_out = per_out_q;
    assign bus.busy       = (state_q == ST_WAIT);
    assign bus.req_drop   = req_drop_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer with hand-computed expectations.
module tb_pwm_cfg_sequencer;
    import pwm_pkg::*;

    localparam logic [3:0] M_DEC_DUTY = 4'b0001;
    localparam logic [3:0] M_INC_DUTY = 4'b0010;
    localparam logic [3:0] M_DEC_FREQ = 4'b0100;
    localparam logic [3:0] M_INC_FREQ = 4'b1000;
    localparam logic [3:0] M_NONE     = 4'b0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   n;

    pwm_cfg_sequencer_if #(.W(8)) bus ();

    pwm_cfg_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests/period_end; returns at the next negedge with results settled.
    task automatic cycle(input logic [3:0] reqs, input logic pe);
        @(negedge clk);
        bus.dec_duty_req = reqs[REQ_DEC_DUTY];
        bus.inc_duty_req = reqs[REQ_INC_DUTY];
        bus.dec_freq_req = reqs[REQ_DEC_FREQ];
        bus.inc_freq_req = reqs[REQ_INC_FREQ];
        bus.period_end   = pe;
        @(negedge clk);
        bus.dec_duty_req = 1'b0;
        bus.inc_duty_req = 1'b0;
        bus.dec_freq_req = 1'b0;
        bus.inc_freq_req = 1'b0;
        bus.period_end   = 1'b0;
    endtask

    task automatic pulse_n(input logic [3:0] reqs, input int cnt);
        for (int i = 0; i < cnt; i++) cycle(reqs, 1'b0);
    endtask

    task automatic commit_until_idle(input int limit, output int cnt);
        cnt = 0;
        while (bus.busy && cnt < limit) begin
            cycle(M_NONE, 1'b1);
            cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_duty_out"}, 32'(bus.duty_out), 0);
        check_eq({tag, "_period_out"}, 32'(bus.period_out), 255);
        check_eq({tag, "_busy"}, 32'(bus.busy), 0);
        check_eq({tag, "_req_drop"}, 32'(bus.req_drop), 0);
        check_eq({tag, "_duty_tgt"}, 32'(dut.duty_tgt_q), 0);
        check_eq({tag, "_per_tgt"}, 32'(dut.per_tgt_q), 255);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.dec_duty_req = 1'b0;
        bus.inc_duty_req = 1'b0;
        bus.dec_freq_req = 1'b0;
        bus.inc_freq_req = 1'b0;
        bus.period_end   = 1'b0;
        do_reset();
        check_reset_state("rst");

        // Idle period_end is ignored.
        for (int i = 0; i < 3; i++) cycle(M_NONE, 1'b1);
        check_eq("idle_pe_duty", 32'(bus.duty_out), 0);
        check_eq("idle_pe_period", 32'(bus.period_out), 255);
        check_eq("idle_pe_busy", 32'(bus.busy), 0);

        // Single inc_duty and two-step ramp.
        cycle(M_INC_DUTY, 1'b0);
        check_eq("inc1_tgt", 32'(dut.duty_tgt_q), 16);
        check_eq("inc1_busy", 32'(bus.busy), 1);
        check_eq("inc1_duty_out", 32'(bus.duty_out), 0);
        cycle(M_NONE, 1'b1);
        check_eq("ramp1_duty", 32'(bus.duty_out), 8);
        check_eq("ramp1_busy", 32'(bus.busy), 1);
        cycle(M_NONE, 1'b1);
        check_eq("ramp2_duty", 32'(bus.duty_out), 16);
        check_eq("ramp2_busy", 32'(bus.busy), 0);

        // Saturation up, then ramp up from 16 to 255 in 30 commits.
        pulse_n(M_INC_DUTY, 17);
        check_eq("sat_hi_tgt", 32'(dut.duty_tgt_q), 255);
        commit_until_idle(40, n);
        check_eq("ramp_up_commits", 32'(n), 30);
        check_eq("ramp_up_duty", 32'(bus.duty_out), 255);

        // Saturation down to 0, ramp down by 8.
        pulse_n(M_DEC_DUTY, 20);
        check_eq("sat_lo_tgt", 32'(dut.duty_tgt_q), 0);
        check_eq("sat_lo_busy", 32'(bus.busy), 1);
        cycle(M_NONE, 1'b1);
        check_eq("ramp_dn1", 32'(bus.duty_out), 247);
        cycle(M_NONE, 1'b1);
        check_eq("ramp_dn2", 32'(bus.duty_out), 239);
        commit_until_idle(40, n);
        check_eq("ramp_dn_commits", 32'(n), 30);
        check_eq("ramp_dn_duty", 32'(bus.duty_out), 0);

        // Duty 128 committed, then period shrinks below it.
        pulse_n(M_INC_DUTY, 8);
        commit_until_idle(40, n);
        check_eq("d128_duty", 32'(bus.duty_out), 128);
        pulse_n(M_INC_FREQ, 8);
        check_eq("f8_per_tgt", 32'(dut.per_tgt_q), 127);
        check_eq("f8_duty_tgt", 32'(dut.duty_tgt_q), 127);
        check_eq("f8_period_held", 32'(bus.period_out), 255);
        cycle(M_NONE, 1'b1);
        check_eq("clamp_period", 32'(bus.period_out), 127);
        check_eq("clamp_duty", 32'(bus.duty_out), 127);
        check_eq("clamp_busy", 32'(bus.busy), 0);
        pulse_n(M_INC_FREQ, 8);
        check_eq("per_min_tgt", 32'(dut.per_tgt_q), 16);
        check_eq("per_min_duty_tgt", 32'(dut.duty_tgt_q), 16);
        cycle(M_NONE, 1'b1);
        check_eq("per_min_period", 32'(bus.period_out), 16);
        check_eq("per_min_duty", 32'(bus.duty_out), 16);

        // Arbitration.
        do_reset();
        check_reset_state("rst2");
        cycle(M_INC_DUTY | M_DEC_FREQ, 1'b0);
        check_eq("arb2_duty_tgt", 32'(dut.duty_tgt_q), 16);
        check_eq("arb2_per_tgt", 32'(dut.per_tgt_q), 255);
        check_eq("arb2_drop", 32'(bus.req_drop), 1);
        cycle(M_NONE, 1'b0);
        check_eq("arb2_drop_clear", 32'(bus.req_drop), 0);
        cycle(M_DEC_DUTY | M_INC_DUTY | M_DEC_FREQ | M_INC_FREQ, 1'b0);
        check_eq("arb4_duty_tgt", 32'(dut.duty_tgt_q), 0);
        check_eq("arb4_per_tgt", 32'(dut.per_tgt_q), 255);
        check_eq("arb4_drop", 32'(bus.req_drop), 1);
        cycle(M_NONE, 1'b1);
        check_eq("arb4_commit_busy", 32'(bus.busy), 0);
        check_eq("arb4_commit_duty", 32'(bus.duty_out), 0);

        // Request coincident with commit, then reset mid-WAIT.
        cycle(M_INC_DUTY, 1'b0);
        cycle(M_INC_DUTY, 1'b1);
        check_eq("coin_duty_out", 32'(bus.duty_out), 8);
        check_eq("coin_duty_tgt", 32'(dut.duty_tgt_q), 32);
        check_eq("coin_busy", 32'(bus.busy), 1);
        cycle(M_NONE, 1'b1);
        check_eq("coin2_duty_out", 32'(bus.duty_out), 16);
        check_eq("coin2_busy", 32'(bus.busy), 1);
        do_reset();
        check_reset_state("rst_wait");
        cycle(M_NONE, 1'b1);
        check_eq("rst_wait_pe_duty", 32'(bus.duty_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
